// File: rtl/ipd_controller.sv
// Inter-packet-delay run controller: gates upstream traffic per run, counts packets,
// applies configuration only between packets and sequences a soft-reset pulse.
module ipd_controller #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int RST_PULSE_CYCLES   = 4
) (
    input  logic                          axi_aclk,
    input  logic                          axi_aresetn,
    input  logic                          cfg_ipd_en,
    input  logic                          cfg_use_reg_val,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_delay,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_pkt_limit,
    input  logic                          cfg_update,
    input  logic                          cfg_start,
    input  logic                          cfg_stop,
    input  logic                          cfg_sw_rst_req,
    input  logic                          mon_tvalid,
    input  logic                          mon_tready,
    input  logic                          mon_tlast,
    output logic                          tx_gate,
    output logic                          ipd_en,
    output logic                          use_reg_val,
    output logic [C_S_AXI_DATA_WIDTH-1:0] delay_reg_val,
    output logic                          sw_rst,
    output logic [C_S_AXI_DATA_WIDTH-1:0] pkt_count,
    output logic                          busy,
    output logic                          done
);

    localparam int         W        = C_S_AXI_DATA_WIDTH;
    localparam logic [7:0] RST_LAST = 8'(RST_PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2,
        ST_RESET    = 2'd3
    } state_t;

    state_t         state_r, next_state_s;
    logic [7:0]     rst_cnt_r, rst_cnt_s;
    logic           in_pkt_r;
    logic           upd_pend_r, upd_pend_s, upd_req_s;
    logic           rst_pend_r, rst_pend_s;
    logic           shadow_en_r, shadow_use_r;
    logic [W-1:0]   shadow_delay_r;
    logic           eff_en_s, eff_use_s;
    logic [W-1:0]   eff_delay_s;
    logic           beat_s, eop_s, boundary_s, limit_hit_s;
    logic           apply_s, done_s;
    logic [W-1:0]   cnt_inc_s, count_s;

    assign beat_s     = mon_tvalid & mon_tready;
    assign eop_s      = beat_s & mon_tlast;
    assign boundary_s = eop_s | (~in_pkt_r & ~beat_s);

    // A same-cycle cfg_update is visible to any transfer made on that edge
    assign eff_en_s    = cfg_update ? cfg_ipd_en      : shadow_en_r;
    assign eff_use_s   = cfg_update ? cfg_use_reg_val : shadow_use_r;
    assign eff_delay_s = cfg_update ? cfg_delay       : shadow_delay_r;
    assign upd_req_s   = upd_pend_r | cfg_update;

    assign cnt_inc_s   = (&pkt_count) ? pkt_count : (pkt_count + W'(1));
    assign limit_hit_s = eop_s & (cfg_pkt_limit != {W{1'b0}}) & (cnt_inc_s == cfg_pkt_limit);

    assign upd_pend_s  = (apply_s | (next_state_s == ST_RESET) | (state_r == ST_RESET)) ? 1'b0 : upd_req_s;

    // Next-state, run-end decisions and counter updates
    always_comb begin
        next_state_s = state_r;
        rst_cnt_s    = 8'd0;
        rst_pend_s   = rst_pend_r;
        apply_s      = 1'b0;
        done_s       = 1'b0;
        count_s      = pkt_count;
        case (state_r)
            ST_IDLE: begin
                rst_pend_s = 1'b0;
                apply_s    = upd_req_s | (cfg_start & ~cfg_sw_rst_req);
                if (cfg_sw_rst_req) begin
                    next_state_s = ST_RESET;
                    count_s      = {W{1'b0}};
                end else if (cfg_start) begin
                    next_state_s = ST_RUN;
                    count_s      = {W{1'b0}};
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                apply_s = upd_req_s & boundary_s;
                count_s = eop_s ? cnt_inc_s : pkt_count;
                if (cfg_sw_rst_req) begin
                    if (boundary_s) begin
                        next_state_s = ST_RESET;
                        count_s      = {W{1'b0}};
                        rst_pend_s   = 1'b0;
                    end else begin
                        next_state_s = ST_STOPPING;
                        rst_pend_s   = 1'b1;
                    end
                end else if (cfg_stop) begin
                    if (boundary_s) begin
                        next_state_s = ST_IDLE;
                        done_s       = 1'b1;
                    end else begin
                        next_state_s = ST_STOPPING;
                    end
                end else if (limit_hit_s) begin
                    next_state_s = ST_IDLE;
                    done_s       = 1'b1;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_STOPPING: begin
                apply_s = upd_req_s & boundary_s;
                if (eop_s) begin
                    if (rst_pend_r | cfg_sw_rst_req) begin
                        next_state_s = ST_RESET;
                        count_s      = {W{1'b0}};
                        rst_pend_s   = 1'b0;
                    end else begin
                        next_state_s = ST_IDLE;
                        count_s      = cnt_inc_s;
                        done_s       = 1'b1;
                    end
                end else begin
                    next_state_s = ST_STOPPING;
                    rst_pend_s   = rst_pend_r | cfg_sw_rst_req;
                end
            end
            ST_RESET: begin
                rst_pend_s = 1'b0;
                count_s    = {W{1'b0}};
                if (rst_cnt_r == RST_LAST) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESET;
                    rst_cnt_s    = rst_cnt_r + 8'd1;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, packet tracking, shadow/applied configuration and registered outputs
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_r        <= ST_IDLE;
            rst_cnt_r      <= 8'd0;
            in_pkt_r       <= 1'b0;
            upd_pend_r     <= 1'b0;
            rst_pend_r     <= 1'b0;
            shadow_en_r    <= 1'b0;
            shadow_use_r   <= 1'b0;
            shadow_delay_r <= {W{1'b0}};
            ipd_en         <= 1'b0;
            use_reg_val    <= 1'b0;
            delay_reg_val  <= {W{1'b0}};
            pkt_count      <= {W{1'b0}};
            tx_gate        <= 1'b0;
            busy           <= 1'b0;
            sw_rst         <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            rst_cnt_r  <= rst_cnt_s;
            in_pkt_r   <= eop_s ? 1'b0 : (beat_s ? 1'b1 : in_pkt_r);
            upd_pend_r <= upd_pend_s;
            rst_pend_r <= rst_pend_s;
            if (cfg_update) begin
                shadow_en_r    <= cfg_ipd_en;
                shadow_use_r   <= cfg_use_reg_val;
                shadow_delay_r <= cfg_delay;
            end
            if (apply_s) begin
                ipd_en        <= eff_en_s;
                use_reg_val   <= eff_use_s;
                delay_reg_val <= eff_delay_s;
            end
            pkt_count <= count_s;
            tx_gate   <= (next_state_s == ST_RUN) | (next_state_s == ST_STOPPING);
            busy      <= (next_state_s != ST_IDLE);
            sw_rst    <= (next_state_s == ST_RESET);
            done      <= done_s;
        end
    end

endmodule

// File: tb/tb_ipd_controller.sv
// Bench for ipd_controller: directed scenarios plus random traffic, all outputs
// compared every cycle against a run-level behavioural model.
module tb_ipd_controller;

    localparam int W    = 8;
    localparam int NRST = 4;

    logic         axi_aclk;
    logic         axi_aresetn;
    logic         cfg_ipd_en, cfg_use_reg_val, cfg_update, cfg_start, cfg_stop, cfg_sw_rst_req;
    logic [W-1:0] cfg_delay, cfg_pkt_limit;
    logic         mon_tvalid, mon_tready, mon_tlast;
    logic         tx_gate, ipd_en, use_reg_val, sw_rst, busy, done;
    logic [W-1:0] delay_reg_val, pkt_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    ipd_controller #(.C_S_AXI_DATA_WIDTH(W), .RST_PULSE_CYCLES(NRST)) dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .cfg_ipd_en(cfg_ipd_en), .cfg_use_reg_val(cfg_use_reg_val),
        .cfg_delay(cfg_delay), .cfg_pkt_limit(cfg_pkt_limit),
        .cfg_update(cfg_update), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_sw_rst_req(cfg_sw_rst_req),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
        .tx_gate(tx_gate), .ipd_en(ipd_en), .use_reg_val(use_reg_val),
        .delay_reg_val(delay_reg_val), .sw_rst(sw_rst), .pkt_count(pkt_count),
        .busy(busy), .done(done)
    );

    initial axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    // Run-level model: running/draining flags plus a reset countdown
    typedef struct packed {
        logic         running;
        logic         draining;
        logic         rst_after;
        logic         upd_pend;
        logic         in_pkt;
        logic         sh_en;
        logic         sh_use;
        logic         en;
        logic         use_r;
        logic         done;
        logic [W-1:0] sh_delay;
        logic [W-1:0] delay;
        logic [W-1:0] count;
        logic [7:0]   rst_left;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t enter_reset(input mdl_t x);
        x.rst_left  = 8'(NRST);
        x.count     = {W{1'b0}};
        x.upd_pend  = 1'b0;
        x.rst_after = 1'b0;
        x.running   = 1'b0;
        x.draining  = 1'b0;
        return x;
    endfunction

    function automatic mdl_t apply_cfg(input mdl_t x);
        x.en    = x.sh_en;
        x.use_r = x.sh_use;
        x.delay = x.sh_delay;
        return x;
    endfunction

    function automatic mdl_t model_step(input mdl_t c);
        mdl_t         n;
        logic         bt, eop, bnd, pend, rst_req, stop_req, hit;
        logic [W-1:0] nc;
        n      = c;
        n.done = 1'b0;
        bt     = mon_tvalid && mon_tready;
        eop    = bt && mon_tlast;
        bnd    = eop || (!c.in_pkt && !bt);
        if (cfg_update) begin
            n.sh_en    = cfg_ipd_en;
            n.sh_use   = cfg_use_reg_val;
            n.sh_delay = cfg_delay;
        end
        pend     = c.upd_pend || cfg_update;
        n.in_pkt = eop ? 1'b0 : (bt ? 1'b1 : c.in_pkt);
        if (c.rst_left != 8'd0) begin
            n.rst_left  = c.rst_left - 8'd1;
            n.count     = {W{1'b0}};
            n.upd_pend  = 1'b0;
            n.rst_after = 1'b0;
        end else if (!c.running) begin
            n.rst_after = 1'b0;
            if (pend || (cfg_start && !cfg_sw_rst_req)) n = apply_cfg(n);
            n.upd_pend = 1'b0;
            if (cfg_sw_rst_req) n = enter_reset(n);
            else if (cfg_start) begin
                n.running = 1'b1;
                n.count   = {W{1'b0}};
            end
        end else begin
            nc = c.count;
            if (eop && (c.count != {W{1'b1}})) nc = c.count + W'(1);
            n.count  = nc;
            rst_req  = c.rst_after || cfg_sw_rst_req;
            stop_req = c.draining || cfg_stop || cfg_sw_rst_req;
            hit      = eop && (cfg_pkt_limit != {W{1'b0}}) && (nc == cfg_pkt_limit);
            if (pend && bnd) begin
                n    = apply_cfg(n);
                pend = 1'b0;
            end
            n.upd_pend = pend;
            if ((stop_req && bnd) || hit) begin
                n.running   = 1'b0;
                n.draining  = 1'b0;
                n.rst_after = 1'b0;
                if (rst_req) n = enter_reset(n);
                else n.done = 1'b1;
            end else if (stop_req) begin
                n.draining  = 1'b1;
                n.rst_after = rst_req;
            end
        end
        return n;
    endfunction

    always @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) m <= '0;
        else              m <= model_step(m);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge axi_aclk) begin
        if (chk_en) begin
            check("tx_gate",       32'(tx_gate),       32'(m.running));
            check("busy",          32'(busy),          32'(m.running || (m.rst_left != 8'd0)));
            check("sw_rst",        32'(sw_rst),        32'(m.rst_left != 8'd0));
            check("done",          32'(done),          32'(m.done));
            check("pkt_count",     32'(pkt_count),     32'(m.count));
            check("ipd_en",        32'(ipd_en),        32'(m.en));
            check("use_reg_val",   32'(use_reg_val),   32'(m.use_r));
            check("delay_reg_val", 32'(delay_reg_val), 32'(m.delay));
        end
    end

    // One clock edge; pulses and beats last exactly one cycle
    task automatic tick();
        @(posedge axi_aclk);
        #2;
        cfg_update     = 1'b0;
        cfg_start      = 1'b0;
        cfg_stop       = 1'b0;
        cfg_sw_rst_req = 1'b0;
        mon_tvalid     = 1'b0;
        mon_tready     = 1'b0;
        mon_tlast      = 1'b0;
    endtask

    task automatic beat(input logic last);
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        mon_tlast  = last;
        tick();
    endtask

    initial begin
        int hi, dn;
        axi_aresetn     = 1'b0;
        cfg_ipd_en      = 1'b0;
        cfg_use_reg_val = 1'b0;
        cfg_delay       = 8'd0;
        cfg_pkt_limit   = 8'd0;
        cfg_update      = 1'b0;
        cfg_start       = 1'b0;
        cfg_stop        = 1'b0;
        cfg_sw_rst_req  = 1'b0;
        mon_tvalid      = 1'b0;
        mon_tready      = 1'b0;
        mon_tlast       = 1'b0;
        repeat (3) tick();
        chk_en      = 1'b1;
        axi_aresetn = 1'b1;
        check("rst_tx_gate", 32'(tx_gate), 32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_count",   32'(pkt_count), 32'd0);
        repeat (3) tick();

        // Limited run of three 4-beat packets
        cfg_ipd_en = 1'b1; cfg_delay = 8'd100; cfg_update = 1'b1; tick();
        cfg_pkt_limit = 8'd3; cfg_start = 1'b1; tick();
        check("lim_gate_open", 32'(tx_gate), 32'd1);
        for (int p = 0; p < 3; p++)
            for (int b = 0; b < 4; b++) beat(b == 3);
        check("lim_count", 32'(pkt_count),     32'd3);
        check("lim_gate",  32'(tx_gate),       32'd0);
        check("lim_done",  32'(done),          32'd1);
        check("lim_en",    32'(ipd_en),        32'd1);
        check("lim_delay", 32'(delay_reg_val), 32'd100);
        tick();
        check("lim_done_clr", 32'(done), 32'd0);

        // Stop mid-packet drains to EOP
        cfg_pkt_limit = 8'd0; cfg_start = 1'b1; tick();
        beat(1'b0);
        cfg_stop = 1'b1; beat(1'b0);
        check("stop_busy", 32'(busy),    32'd1);
        check("stop_gate", 32'(tx_gate), 32'd1);
        beat(1'b0); beat(1'b0);
        check("stop_gate_held", 32'(tx_gate), 32'd1);
        beat(1'b1);
        check("stop_end_gate", 32'(tx_gate), 32'd0);
        check("stop_end_done", 32'(done),    32'd1);
        tick();
        check("stop_done_once", 32'(done), 32'd0);

        // Mid-packet update is deferred to the packet boundary
        cfg_start = 1'b1; tick();
        beat(1'b0);
        cfg_delay = 8'd50; cfg_update = 1'b1; beat(1'b0);
        check("upd_hold_a", 32'(delay_reg_val), 32'd100);
        beat(1'b0); beat(1'b0);
        check("upd_hold_b", 32'(delay_reg_val), 32'd100);
        beat(1'b1);
        check("upd_applied", 32'(delay_reg_val), 32'd50);
        cfg_stop = 1'b1; tick();

        // Soft reset requested mid-packet
        cfg_start = 1'b1; tick();
        beat(1'b0);
        cfg_sw_rst_req = 1'b1; beat(1'b0);
        check("srst_wait", 32'(sw_rst), 32'd0);
        beat(1'b0); beat(1'b1);
        hi = 0; dn = 0;
        for (int i = 0; i < 10; i++) begin
            if (sw_rst) hi++;
            if (done) dn++;
            tick();
        end
        check("srst_len",   32'(hi), 32'd4);
        check("srst_done",  32'(dn), 32'd0);
        check("srst_count", 32'(pkt_count), 32'd0);
        check("srst_idle",  32'(busy), 32'd0);
        check("srst_keep_delay", 32'(delay_reg_val), 32'd50);

        // Stop+reset together in IDLE, then hard reset during RESET
        cfg_stop = 1'b1; cfg_sw_rst_req = 1'b1; tick();
        check("both_rst", 32'(sw_rst), 32'd1);
        tick();
        #1 axi_aresetn = 1'b0;
        #1;
        check("hard_sw_rst", 32'(sw_rst),        32'd0);
        check("hard_busy",   32'(busy),          32'd0);
        check("hard_en",     32'(ipd_en),        32'd0);
        check("hard_delay",  32'(delay_reg_val), 32'd0);
        check("hard_gate",   32'(tx_gate),       32'd0);
        tick();
        axi_aresetn = 1'b1;
        tick();

        // Unlimited run saturates the packet counter
        cfg_pkt_limit = 8'd0; cfg_start = 1'b1; tick();
        for (int i = 0; i < 260; i++) beat(1'b1);
        check("sat_count", 32'(pkt_count), 32'd255);
        check("sat_gate",  32'(tx_gate),   32'd1);
        cfg_stop = 1'b1; tick();

        // Random traffic and commands
        for (int i = 0; i < 4000; i++) begin
            mon_tvalid      = ($urandom_range(0, 3) != 0);
            mon_tready      = ($urandom_range(0, 3) != 0);
            mon_tlast       = ($urandom_range(0, 3) == 0);
            cfg_start       = ($urandom_range(0, 15) == 0);
            cfg_stop        = ($urandom_range(0, 39) == 0);
            cfg_sw_rst_req  = ($urandom_range(0, 99) == 0);
            cfg_update      = ($urandom_range(0, 19) == 0);
            cfg_ipd_en      = 1'($urandom_range(0, 1));
            cfg_use_reg_val = 1'($urandom_range(0, 1));
            cfg_delay       = 8'($urandom);
            if ($urandom_range(0, 63) == 0) cfg_pkt_limit = 8'($urandom_range(0, 4));
            @(posedge axi_aclk);
            #2;
        end
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
